// File: rtl/wb_irq_ctrl_pkg.sv
// Shared definitions for the Wishbone interrupt controller: register map,
// interrupt id type, bus response states and a byte-lane helper.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_STATUS  = 2'd0;
  localparam logic [1:0] IRQ_PENDING = 2'd1;
  localparam logic [1:0] IRQ_ENABLE  = 2'd2;
  localparam logic [1:0] IRQ_ACTIVE  = 2'd3;

  typedef logic [4:0] irq_id_t;

  typedef enum logic [1:0] {
    BUS_DROP = 2'd0,
    BUS_IDLE = 2'd1,
    BUS_RESP = 2'd2
  } bus_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// Wishbone B3 classic slave signal bundle for the interrupt controller.
interface wb_irq_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_irq_ctrl_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous interrupt source.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: synchronised sources, edge/level pending,
// enable mask, registered irq and lowest-index id.
//
// state    | meaning
// BUS_DROP | after reset; wait for cyc&stb low so a cut-off access never acks
// BUS_IDLE | ready; cyc&stb accepts the access and performs it this edge
// BUS_RESP | ack/err high for one cycle; request ignored, forces a low gap
module wb_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] EDGE_MASK   = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  wb_irq_ctrl_if.slave       wb,
  output logic               irq_o,
  output irq_id_t            irq_id_o
);

  localparam logic [NUM_IRQ-1:0] EDGE_BITS = EDGE_MASK[NUM_IRQ-1:0];

  function automatic irq_id_t prio_enc(input logic [NUM_IRQ-1:0] v);
    irq_id_t id;
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) id = irq_id_t'(i);
    end
    return id;
  endfunction

  logic [NUM_IRQ-1:0] w_sync;
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] r_pend_edge;
  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_clr;

  bus_state_e r_state;
  bus_state_e w_state_nxt;
  logic       w_req;
  logic       w_accept;
  logic       w_ro;
  logic       w_bad;
  logic       w_wr;
  logic [1:0] w_addr;
  logic [31:0] w_lane;
  logic [31:0] w_wdat;
  logic [31:0] w_rdat;
  logic       r_ack;
  logic       r_err;
  logic [31:0] r_dat;
  logic       r_irq;
  irq_id_t    r_id;
  logic       w_unused;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk  (wb_clk_i),
      .i_rst_n(wb_rst_n_i),
      .i_d    (irq_src_i[g]),
      .o_q    (w_sync[g])
    );
  end

  // Level sources follow the synchronised input directly; only edge bits are stored.
  assign w_rise   = w_sync & ~r_hist & EDGE_BITS;
  assign w_pend   = (r_pend_edge & EDGE_BITS) | (w_sync & ~EDGE_BITS);
  assign w_active = w_pend & r_en;

  assign w_req  = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_addr = wb.wb_adr_i[3:2];
  assign w_ro   = (w_addr == IRQ_STATUS) || (w_addr == IRQ_ACTIVE);
  assign w_bad  = w_accept & wb.wb_we_i & w_ro;
  assign w_wr   = w_accept & wb.wb_we_i & ~w_ro;
  assign w_lane = lane_mask(wb.wb_sel_i);
  assign w_wdat = wb.wb_dat_i & w_lane;
  assign w_clr  = (w_wr && (w_addr == IRQ_PENDING)) ? (w_wdat[NUM_IRQ-1:0] & EDGE_BITS)
                                                     : '0;

  assign w_unused = ^{wb.wb_adr_i, w_wdat, w_lane, wb.wb_cti_i, wb.wb_bte_i};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      BUS_DROP: if (!w_req) w_state_nxt = BUS_IDLE;
      BUS_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = BUS_RESP;
        end
      end
      BUS_RESP: w_state_nxt = BUS_IDLE;
      default:  w_state_nxt = BUS_DROP;
    endcase
  end

  always_comb begin
    w_rdat = '0;
    unique case (w_addr)
      IRQ_STATUS:  w_rdat[NUM_IRQ-1:0] = w_sync;
      IRQ_PENDING: w_rdat[NUM_IRQ-1:0] = w_pend;
      IRQ_ENABLE:  w_rdat[NUM_IRQ-1:0] = r_en;
      IRQ_ACTIVE:  w_rdat[NUM_IRQ-1:0] = w_active;
      default:     w_rdat = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= BUS_DROP;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_accept & ~w_bad;
      r_err   <= w_bad;
      r_dat   <= (w_accept && !w_bad) ? w_rdat : '0;
    end
  end

  // Set beats clear: a new edge landing with a W1C leaves the bit pending.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_hist      <= '0;
      r_pend_edge <= '0;
      r_en        <= '0;
    end else begin
      r_hist      <= w_sync;
      r_pend_edge <= (r_pend_edge & ~w_clr) | w_rise;
      if (w_wr && (w_addr == IRQ_ENABLE)) begin
        r_en <= (r_en & ~w_lane[NUM_IRQ-1:0]) | w_wdat[NUM_IRQ-1:0];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_irq <= 1'b0;
      r_id  <= '0;
    end else begin
      r_irq <= |w_active;
      r_id  <= prio_enc(w_active);
    end
  end

  assign irq_o       = r_irq;
  assign irq_id_o    = r_id;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed self-checking bench for wb_irq_ctrl (8 sources, sources 0/2/5 edge).
module tb_wb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NUM_IRQ = 8;
  localparam logic [31:0] A_STATUS  = 32'h0;
  localparam logic [31:0] A_PENDING = 32'h4;
  localparam logic [31:0] A_ENABLE  = 32'h8;
  localparam logic [31:0] A_ACTIVE  = 32'hC;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_IRQ-1:0] src = '0;
  logic               irq;
  irq_id_t            irq_id;
  int                 n_checks = 0;
  int                 n_fail = 0;

  wb_irq_ctrl_if wb ();

  wb_irq_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .EDGE_MASK  (32'h25),
    .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .irq_src_i (src),
    .wb        (wb),
    .irq_o     (irq),
    .irq_id_o  (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat,
                      output logic ack, output logic err, output int lat);
    @(negedge clk);
    wb.wb_adr_i = adr;
    wb.wb_dat_i = wdat;
    wb.wb_sel_i = sel;
    wb.wb_we_i  = we;
    wb.wb_cti_i = 3'b111;
    wb.wb_bte_i = 2'b01;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o || wb.wb_err_o) begin
        lat  = n;
        ack  = wb.wb_ack_o;
        err  = wb.wb_err_o;
        rdat = wb.wb_dat_o;
        break;
      end
    end
    @(negedge clk);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    chk("responded", 32'(lat != 0), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d; logic a, e; int l;
    xfer(1'b0, adr, 32'h0, 4'hF, d, a, e, l);
    chk({tag, "_ack"}, 32'(a), 32'd1);
    chk(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] d; logic a, e; int l;
    xfer(1'b1, adr, dat, sel, d, a, e, l);
    chk({tag, "_ack"}, 32'(a), 32'd1);
    chk({tag, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic wr_ro(input string tag, input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d; logic a, e; int l;
    xfer(1'b1, adr, dat, 4'hF, d, a, e, l);
    chk({tag, "_err"}, 32'(e), 32'd1);
    chk({tag, "_ack"}, 32'(a), 32'd0);
    chk({tag, "_dat"}, d, 32'd0);
  endtask

  initial begin
    logic [31:0] d; logic a, e; int l;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_cti_i = '0; wb.wb_bte_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wb.wb_ack_o), 32'd0);
    chk("rst_err", 32'(wb.wb_err_o), 32'd0);
    chk("rst_dat", wb.wb_dat_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(1'b0, A_STATUS, 32'h0, 4'hF, d, a, e, l);
    chk("lat_status", 32'(l), 32'd1);
    chk("rd0_status", d, 32'd0);
    rd("rd0_pending", A_PENDING, 32'd0);
    rd("rd0_enable", A_ENABLE, 32'd0);
    rd("rd0_active", A_ACTIVE, 32'd0);
    chk("rd0_irq", 32'(irq), 32'd0);
    chk("rty", 32'(wb.wb_rty_o), 32'd0);

    // Edge source 0: irq after 4 edges
    wr("en1", A_ENABLE, 32'h1, 4'hF);
    src[0] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("edge_lat%0d", c), 32'(irq), 32'(c == 4));
    end
    chk("edge_id", 32'(irq_id), 32'd0);
    @(negedge clk);
    src[0] = 1'b0;
    repeat (3) @(posedge clk);
    rd("edge_pend", A_PENDING, 32'h1);
    wr("edge_w1c", A_PENDING, 32'h1, 4'hF);
    chk("w1c_irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("w1c_irq_clr", 32'(irq), 32'd0);

    // Level source 3
    wr("en8", A_ENABLE, 32'h8, 4'hF);
    src[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lvl_irq", 32'(irq), 32'd1);
    chk("lvl_id", 32'(irq_id), 32'd3);
    rd("lvl_pend", A_PENDING, 32'h8);
    wr("lvl_w1c", A_PENDING, 32'h8, 4'hF);
    rd("lvl_pend2", A_PENDING, 32'h8);
    src[3] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("lvl_drop%0d", c), 32'(irq), 32'(c < 3));
    end

    // Priority between sources 2 and 5
    @(negedge clk);
    src[2] = 1'b1; src[5] = 1'b1;
    repeat (2) @(negedge clk);
    src[2] = 1'b0; src[5] = 1'b0;
    repeat (4) @(posedge clk);
    rd("pri_pend", A_PENDING, 32'h24);
    rd("pri_act0", A_ACTIVE, 32'h0);
    chk("pri_irq0", 32'(irq), 32'd0);
    wr("en24", A_ENABLE, 32'h24, 4'hF);
    @(posedge clk); #1;
    chk("pri_irq", 32'(irq), 32'd1);
    chk("pri_id2", 32'(irq_id), 32'd2);
    wr("en20", A_ENABLE, 32'h20, 4'hF);
    @(posedge clk); #1;
    chk("pri_id5", 32'(irq_id), 32'd5);
    rd("pri_act", A_ACTIVE, 32'h20);
    wr("pri_w1c", A_PENDING, 32'h24, 4'hF);
    wr("en0", A_ENABLE, 32'h0, 4'hF);
    rd("pri_pend0", A_PENDING, 32'h0);

    // Edge arriving in the same cycle as its W1C
    src[0] = 1'b1;
    @(negedge clk);
    wr("race_w1c", A_PENDING, 32'h1, 4'hF);
    rd("race_pend", A_PENDING, 32'h1);
    wr("race_w1c2", A_PENDING, 32'h1, 4'hF);
    rd("race_pend2", A_PENDING, 32'h0);

    // Read-only writes and byte lanes
    rd("st_before", A_STATUS, 32'h1);
    wr_ro("st_wr", A_STATUS, 32'hFF);
    rd("st_after", A_STATUS, 32'h1);
    wr_ro("act_wr", A_ACTIVE, 32'hFF);
    wr("en81", A_ENABLE, 32'h81, 4'hF);
    wr("en_lane1", A_ENABLE, 32'hFFFF, 4'b0010);
    rd("en_lane1_rd", A_ENABLE, 32'h81);
    wr("en_lane0", A_ENABLE, 32'h1234_5633, 4'b0001);
    rd("en_lane0_rd", A_ENABLE, 32'h33);
    rd("en_hiadr", 32'hABCD_0008, 32'h33);
    src[0] = 1'b0;

    // Reset in the middle of an access
    @(negedge clk);
    wb.wb_adr_i = A_ENABLE; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(wb.wb_ack_o), 32'd0);
    chk("mid_rst_dat", wb.wb_dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_resp%0d", c), 32'(wb.wb_ack_o | wb.wb_err_o), 32'd0);
    end
    @(negedge clk);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    rd("post_rst_en", A_ENABLE, 32'h0);
    rd("post_rst_pend", A_PENDING, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
